// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM encoding and
// the helpers that decide whether a request may go to memory.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Codes 3, 6 and 7 are not access sizes.
  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU: size_legal = 1'b1;
      default:                                  size_legal = 1'b0;
    endcase
  endfunction

  // Halves must sit on an even byte, words on a multiple of four.
  function automatic logic addr_aligned(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      LDST_H, LDST_HU: addr_aligned = (lo[0] == 1'b0);
      LDST_W:          addr_aligned = (lo == 2'b00);
      default:         addr_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: picks the addressed byte/half lane out of the memory
// word and sign- or zero-extends it to the full data width.
module lsu_load_fmt
  import riscv_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [DATA_W-1:0] rd
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Lane select followed by extension; sized casts of signed lanes sign-extend.
  always_comb begin
    byte_s = $signed(mem_rd[8*addr_lo +: 8]);
    half_s = addr_lo[1] ? $signed(mem_rd[31:16]) : $signed(mem_rd[15:0]);
    rd     = mem_rd;
    case (size)
      LDST_B:  rd = DATA_W'(byte_s);
      LDST_H:  rd = DATA_W'(half_s);
      LDST_BU: rd = {{(DATA_W-8){1'b0}}, byte_s};
      LDST_HU: rd = {{(DATA_W-16){1'b0}}, half_s};
      default: rd = mem_rd;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: turns a byte/half/word core request into one aligned word
// access with byte enables, stalls the core until memory answers and returns
// the extended load data.
module lsu
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  input  logic              mem_ready_i
);

  lsu_state_e        state;
  logic [2:0]        size_q;
  logic [1:0]        lane_q;
  logic              access_ok;
  logic [DATA_W-1:0] fmt_rd;

  // Byte enables of a store for the given size and low address bits.
  function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] lo);
    case (size)
      LDST_B:  store_be = 4'b0001 << lo;
      LDST_H:  store_be = 4'b0011 << {lo[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across every lane so the enabled bytes pick it up.
  function automatic logic [DATA_W-1:0] store_wd(input logic [2:0] size, input logic [DATA_W-1:0] wd);
    case (size)
      LDST_B:  store_wd = {4{wd[7:0]}};
      LDST_H:  store_wd = {2{wd[15:0]}};
      default: store_wd = wd;
    endcase
  endfunction

  assign access_ok = size_legal(core_size_i) && addr_aligned(core_size_i, core_addr_i[1:0]);

  // Core must hold while a request is being accepted or memory is pending.
  assign core_stall_o = ((state == LSU_IDLE) && core_req_i) || (state == LSU_BUSY);

  // Formatting uses the captured size and lane, never the live core address.
  lsu_load_fmt #(.DATA_W(DATA_W)) u_load_fmt (
    .size    (size_q),
    .addr_lo (lane_q),
    .mem_rd  (mem_rd_i),
    .rd      (fmt_rd)
  );

  // Access FSM with all memory-side and core-side outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= LSU_IDLE;
      core_rd_o  <= '0;
      core_err_o <= 1'b0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_be_o   <= 4'b0000;
      mem_addr_o <= '0;
      mem_wd_o   <= '0;
      size_q     <= 3'd0;
      lane_q     <= 2'd0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (core_req_i) begin
            if (access_ok) begin
              mem_req_o  <= 1'b1;
              mem_we_o   <= core_we_i;
              mem_be_o   <= core_we_i ? store_be(core_size_i, core_addr_i[1:0]) : 4'b1111;
              mem_addr_o <= {core_addr_i[ADDR_W-1:2], 2'b00};
              mem_wd_o   <= store_wd(core_size_i, core_wd_i);
              size_q     <= core_size_i;
              lane_q     <= core_addr_i[1:0];
              state      <= LSU_BUSY;
            end else begin
              core_err_o <= 1'b1;
              state      <= LSU_DONE;
            end
          end
        end
        LSU_BUSY: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) core_rd_o <= fmt_rd;
            state <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          core_err_o <= 1'b0;
          state      <= LSU_IDLE;
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the load/store unit: a table of single accesses plus
// hand-written sequences for reset, back-to-back and idle-ready cases.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  int tests  = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  lsu dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .core_err_o   (core_err_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wd_o     (mem_wd_o),
    .mem_rd_i     (mem_rd_i),
    .mem_ready_i  (mem_ready_i)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] res;
    int          stall;
    int          nreq;
    int          nerr;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd, input int waits,
                              input logic [3:0] be, input logic [31:0] mwd, input logic [31:0] res,
                              input int stall, input int nreq, input int nerr);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.rd = rd; v.waits = waits;
    v.be = be; v.mwd = mwd; v.res = res; v.stall = stall; v.nreq = nreq; v.nerr = nerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drives one access from IDLE and follows it to the DONE cycle; core_req_i
  // is left high through DONE, the caller decides when to drop it.
  task automatic do_access(input vec_t v, input string nm);
    int  stall_n = 0;
    int  req_n   = 0;
    int  err_n   = 0;
    int  wait_n  = 0;
    logic done   = 1'b0;
    core_req_i  = 1'b1;
    core_we_i   = v.we;
    core_size_i = v.size;
    core_addr_i = v.addr;
    core_wd_i   = v.wd;
    mem_rd_i    = v.rd;
    mem_ready_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      if (core_stall_o) stall_n++;
      if (core_err_o) err_n++;
      if (mem_req_o) begin
        req_n++;
        chk({nm, " mem_addr"}, mem_addr_o, v.addr & 32'hFFFF_FFFC);
        chk({nm, " mem_be"}, {28'd0, mem_be_o}, {28'd0, v.be});
        chk({nm, " mem_we"}, {31'd0, mem_we_o}, {31'd0, v.we});
        if (v.we) chk({nm, " mem_wd"}, mem_wd_o, v.mwd);
        mem_ready_i = (wait_n == v.waits);
        wait_n++;
      end else begin
        mem_ready_i = 1'b0;
      end
      if (!core_stall_o) begin
        done = 1'b1;
        chk({nm, " core_rd"}, core_rd_o, v.res);
      end
      @(posedge clk_i);
      #1;
      mem_ready_i = 1'b0;
    end
    if (!done) chk({nm, " timeout"}, 32'd0, 32'd1);
    chk({nm, " stall_cycles"}, stall_n, v.stall);
    chk({nm, " req_cycles"}, req_n, v.nreq);
    chk({nm, " err_cycles"}, err_n, v.nerr);
  endtask

  initial begin
    //            we    size  addr          wd            rd            wt be     mwd           res           st rq er
    vt[0]  = mk(1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'hF, 32'h0,        32'hFFFF_FF80, 2, 1, 0);
    vt[1]  = mk(1'b0, 3'd4, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 4'hF, 32'h0,        32'h0000_0080, 2, 1, 0);
    vt[2]  = mk(1'b1, 3'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        3, 4'hC, 32'hBEEF_BEEF, 32'h0000_0080, 5, 4, 0);
    vt[3]  = mk(1'b0, 3'd2, 32'h0000_3001, 32'h0,        32'h0,        0, 4'hF, 32'h0,        32'h0000_0080, 1, 0, 1);
    vt[4]  = mk(1'b0, 3'd3, 32'h0000_3000, 32'h0,        32'h0,        0, 4'hF, 32'h0,        32'h0000_0080, 1, 0, 1);
    vt[5]  = mk(1'b0, 3'd1, 32'h0000_1002, 32'h0,        32'h80FF_1234, 1, 4'hF, 32'h0,        32'hFFFF_80FF, 3, 2, 0);
    vt[6]  = mk(1'b0, 3'd5, 32'h0000_1000, 32'h0,        32'h0000_F234, 0, 4'hF, 32'h0,        32'h0000_F234, 2, 1, 0);
    vt[7]  = mk(1'b1, 3'd0, 32'h0000_4001, 32'h1234_5678, 32'h0,        0, 4'h2, 32'h7878_7878, 32'h0000_F234, 2, 1, 0);
    vt[8]  = mk(1'b1, 3'd1, 32'h0000_4001, 32'h1234_5678, 32'h0,        0, 4'hF, 32'h0,        32'h0000_F234, 1, 0, 1);
    vt[9]  = mk(1'b0, 3'd2, 32'h0000_5000, 32'h0,        32'hCAFE_BABE, 2, 4'hF, 32'h0,        32'hCAFE_BABE, 4, 3, 0);
    vt[10] = mk(1'b0, 3'd6, 32'h0000_5000, 32'h0,        32'h0,        0, 4'hF, 32'h0,        32'hCAFE_BABE, 1, 0, 1);
    vt[11] = mk(1'b1, 3'd7, 32'h0000_5000, 32'h0,        32'h0,        0, 4'hF, 32'h0,        32'hCAFE_BABE, 1, 0, 1);
    vt[12] = mk(1'b0, 3'd0, 32'h0000_5002, 32'h0,        32'h007F_0000, 0, 4'hF, 32'h0,        32'h0000_007F, 2, 1, 0);

    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0; mem_rd_i = 32'h0; mem_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("reset mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("reset mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("reset mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("reset mem_addr", mem_addr_o, 32'd0);
    chk("reset mem_wd", mem_wd_o, 32'd0);
    chk("reset core_rd", core_rd_o, 32'd0);
    chk("reset core_err", {31'd0, core_err_o}, 32'd0);
    chk("reset stall", {31'd0, core_stall_o}, 32'd0);
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 13; i++) begin
      do_access(vt[i], $sformatf("vec%0d", i));
      core_req_i = 1'b0;
    end

    // Ready while idle with no request must be ignored.
    mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("idle_ready mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("idle_ready stall", {31'd0, core_stall_o}, 32'd0);
      chk("idle_ready err", {31'd0, core_err_o}, 32'd0);
      chk("idle_ready core_rd", core_rd_o, 32'h0000_007F);
    end
    @(posedge clk_i);
    #1;
    mem_ready_i = 1'b0;

    // Reset while memory is still pending.
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
    core_addr_i = 32'h0000_6000; mem_rd_i = 32'h1234_5678;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rst_busy req_before", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1; core_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_busy stall", {31'd0, core_stall_o}, 32'd0);
    chk("rst_busy core_rd", core_rd_o, 32'd0);
    mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy late_ready mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_busy late_ready core_rd", core_rd_o, 32'd0);
    chk("rst_busy late_ready stall", {31'd0, core_stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    do_access(vt[1], "post_reset");
    core_req_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Back-to-back: request stays high through both DONE cycles.
    do_access(mk(1'b1, 3'd2, 32'h0000_0010, 32'h1122_3344, 32'h0, 0, 4'hF,
                 32'h1122_3344, 32'h0000_0080, 2, 1, 0), "b2b_store");
    do_access(mk(1'b0, 3'd5, 32'h0000_0012, 32'h0, 32'hABCD_5678, 0, 4'hF,
                 32'h0, 32'h0000_ABCD, 2, 1, 0), "b2b_load");
    @(negedge clk_i);
    chk("b2b held_req no_access", {31'd0, mem_req_o}, 32'd0);
    core_req_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
